// File: rtl/qed_pkg.sv
// Shared constants for the QED replay queue: RISC-V opcodes, the NOP
// encoding, register-field bit positions and the replay FSM state type.
package qed_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h00000013;

    localparam int OPC_HI = 6;
    localparam int OPC_LO = 0;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 7;
    localparam int RS1_HI = 19;
    localparam int RS1_LO = 15;
    localparam int RS2_HI = 24;
    localparam int RS2_LO = 20;

    typedef enum logic [0:0] {
        ST_ORIG = 1'b0,
        ST_DUP  = 1'b1
    } state_t;

endpackage

// File: rtl/qed_inst_remap.sv
// Combinational register remap for QED duplicates: every nonzero register
// field the opcode actually uses is shifted by REG_OFFSET (mod 32) so the
// duplicate runs in the other half of the register file. Immediates,
// funct fields and the opcode are passed through untouched.
module qed_inst_remap
    import qed_pkg::*;
#(
    parameter int INST_LEN   = 32,
    parameter int REG_OFFSET = 16
) (
    input  logic [INST_LEN-1:0] inst,
    output logic [INST_LEN-1:0] inst_remap
);

    // bit 0 = rd, bit 1 = rs1, bit 2 = rs2
    logic [2:0] fld_used;
    logic [4:0] fld_in  [3];
    logic [4:0] fld_out [3];

    // Decide which register fields this opcode really reads or writes
    always_comb begin
        fld_used = 3'b000;
        case (inst[OPC_HI:OPC_LO])
            OPC_OP:                fld_used = 3'b111;
            OPC_OP_IMM, OPC_LOAD:  fld_used = 3'b011;
            OPC_STORE:             fld_used = 3'b110;
            OPC_LUI, OPC_AUIPC:    fld_used = 3'b001;
            default:               fld_used = 3'b000;
        endcase
    end

    assign fld_in[0] = inst[RD_HI:RD_LO];
    assign fld_in[1] = inst[RS1_HI:RS1_LO];
    assign fld_in[2] = inst[RS2_HI:RS2_LO];

    // x0 is hard-wired zero in both copies, so it is never relocated
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_fld
            assign fld_out[gi] = (fld_used[gi] && (fld_in[gi] != 5'd0))
                               ? fld_in[gi] + 5'(REG_OFFSET)
                               : fld_in[gi];
        end
    endgenerate

    // Splice the relocated fields back into the original encoding
    always_comb begin
        inst_remap                = inst;
        inst_remap[RD_HI:RD_LO]   = fld_out[0];
        inst_remap[RS1_HI:RS1_LO] = fld_out[1];
        inst_remap[RS2_HI:RS2_LO] = fld_out[2];
    end

endmodule

// File: rtl/qed_replay_queue.sv
// QED replay queue: passes original instructions through to the core with
// one cycle of latency while recording a remapped duplicate of each, then
// on request replays the recorded duplicates in order.
module qed_replay_queue
    import qed_pkg::*;
#(
    parameter int INST_LEN   = 32,
    parameter int DEPTH      = 8,
    parameter int REG_OFFSET = 16
) (
    input  logic                       clk,
    input  logic                       reset_x,
    input  logic                       ena,
    input  logic                       exec_dup,
    input  logic [INST_LEN-1:0]        ifu_instruction,
    input  logic                       ifu_vld,
    output logic                       ifu_rdy,
    input  logic                       stall_IF,
    output logic [INST_LEN-1:0]        qed_instruction,
    output logic                       qed_vld_out,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       dup_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage is deliberately left without reset; occupancy lives in count_reg
    logic [INST_LEN-1:0] mem [DEPTH];

    state_t              state_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [INST_LEN-1:0] qed_inst_reg;
    logic                qed_vld_reg;
    logic                dup_done_reg;

    logic [INST_LEN-1:0] dup_inst;
    logic                adv;
    logic                full;
    logic                empty;
    logic                start_dup;
    logic                push;
    logic                pop;
    logic                last_pop;

    qed_inst_remap #(
        .INST_LEN   (INST_LEN),
        .REG_OFFSET (REG_OFFSET)
    ) u_remap (
        .inst       (ifu_instruction),
        .inst_remap (dup_inst)
    );

    assign adv       = ena & ~stall_IF;
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    // A replay request only counts when there is something to replay
    assign start_dup = (state_reg == ST_ORIG) & exec_dup & ~empty;
    assign ifu_rdy   = (state_reg == ST_ORIG) & ~full & ~start_dup;
    assign push      = adv & ifu_vld & ifu_rdy;
    assign pop       = adv & ((state_reg == ST_DUP) | start_dup) & ~empty;
    assign last_pop  = pop & (count_reg == CNT_W'(1));

    // Duplicate storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= dup_inst;
        end
    end

    // Replay FSM, pointers, occupancy and the registered output stage
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_reg    <= ST_ORIG;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            qed_inst_reg <= INST_LEN'(NOP_INST);
            qed_vld_reg  <= 1'b0;
            dup_done_reg <= 1'b0;
        end else if (adv) begin
            if (pop) begin
                qed_inst_reg <= mem[rd_ptr_reg];
                qed_vld_reg  <= 1'b1;
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                count_reg    <= count_reg - 1'b1;
            end else if (push) begin
                qed_inst_reg <= ifu_instruction;
                qed_vld_reg  <= 1'b1;
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                count_reg    <= count_reg + 1'b1;
            end else begin
                qed_inst_reg <= INST_LEN'(NOP_INST);
                qed_vld_reg  <= 1'b0;
            end
            dup_done_reg <= last_pop;
            // A single-entry replay finishes in the same cycle it starts
            if (last_pop) begin
                state_reg <= ST_ORIG;
            end else if (start_dup) begin
                state_reg <= ST_DUP;
            end
        end
    end

    assign qed_instruction = qed_inst_reg;
    assign qed_vld_out     = qed_vld_reg;
    assign q_count         = count_reg;
    assign dup_done        = dup_done_reg;

endmodule

// File: tb/tb_qed_replay_queue.sv
// Self-checking bench for qed_replay_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_qed_replay_queue;

    localparam int DEPTH      = 8;
    localparam int REG_OFFSET = 16;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset_x;
    logic        ena;
    logic        exec_dup;
    logic [31:0] ifu_instruction;
    logic        ifu_vld;
    logic        ifu_rdy;
    logic        stall_IF;
    logic [31:0] qed_instruction;
    logic        qed_vld_out;
    logic [3:0]  q_count;
    logic        dup_done;

    qed_replay_queue #(
        .INST_LEN   (32),
        .DEPTH      (DEPTH),
        .REG_OFFSET (REG_OFFSET)
    ) dut (
        .clk             (clk),
        .reset_x         (reset_x),
        .ena             (ena),
        .exec_dup        (exec_dup),
        .ifu_instruction (ifu_instruction),
        .ifu_vld         (ifu_vld),
        .ifu_rdy         (ifu_rdy),
        .stall_IF        (stall_IF),
        .qed_instruction (qed_instruction),
        .qed_vld_out     (qed_vld_out),
        .q_count         (q_count),
        .dup_done        (dup_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] ref_q[$];
    bit          ref_dup;
    logic [31:0] ref_out;
    bit          ref_vld;
    bit          ref_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Relocate used, nonzero register fields by REG_OFFSET using arithmetic
    function automatic logic [31:0] ref_remap(input logic [31:0] i);
        int          op;
        int          f;
        int          sh[3];
        bit          en[3];
        logic [31:0] r;
        sh = '{7, 15, 20};
        en = '{0, 0, 0};
        op = int'(i % 128);
        if (op == 51)                 en = '{1, 1, 1};
        else if (op == 19 || op == 3) en = '{1, 1, 0};
        else if (op == 35)            en = '{0, 1, 1};
        else if (op == 55 || op == 23) en = '{1, 0, 0};
        r = i;
        for (int k = 0; k < 3; k++) begin
            f = int'((i >> sh[k]) % 32);
            if (en[k] && f != 0)
                r = r - (32'(f) << sh[k]) + (32'((f + REG_OFFSET) % 32) << sh[k]);
        end
        return r;
    endfunction

    function automatic bit ref_rdy(input bit ex);
        return !ref_dup && (ref_q.size() < DEPTH) && !(ex && ref_q.size() > 0);
    endfunction

    task automatic ref_reset();
        ref_q.delete();
        ref_dup  = 0;
        ref_out  = NOP;
        ref_vld  = 0;
        ref_done = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".inst"},  qed_instruction, ref_out);
        chk({tag, ".vld"},   32'(qed_vld_out), 32'(ref_vld));
        chk({tag, ".count"}, 32'(q_count), 32'(ref_q.size()));
        chk({tag, ".done"},  32'(dup_done), 32'(ref_done));
    endtask

    // One clock of stimulus; entered and left on a falling edge
    task automatic step(input bit e, input bit st, input bit ex, input bit v, input logic [31:0] ins);
        bit acc_rdy;
        ena = e; stall_IF = st; exec_dup = ex; ifu_vld = v; ifu_instruction = ins;
        #1;
        acc_rdy = ref_rdy(ex);
        chk("ifu_rdy", 32'(ifu_rdy), 32'(acc_rdy));
        if (e && !st) begin
            if (ref_dup || (ex && ref_q.size() > 0)) begin
                ref_out  = ref_q.pop_front();
                ref_vld  = 1;
                ref_done = (ref_q.size() == 0);
                ref_dup  = (ref_q.size() != 0);
            end else if (v && acc_rdy) begin
                ref_out  = ins;
                ref_vld  = 1;
                ref_done = 0;
                ref_q.push_back(ref_remap(ins));
            end else begin
                ref_out  = NOP;
                ref_vld  = 0;
                ref_done = 0;
            end
        end
        @(negedge clk);
        chk_outputs("cyc");
    endtask

    // Assert reset between edges, check the asynchronous clear, release
    task automatic do_reset();
        #2 reset_x = 1'b0;
        #1;
        ref_reset();
        chk_outputs("rst");
        @(negedge clk);
        reset_x = 1'b1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops[8];
        logic [31:0] t;
        ops = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd55, 7'd23, 7'd99, 7'd111};
        t = $urandom();
        t[6:0] = ops[$urandom_range(0, 7)];
        if ($urandom_range(0, 3) == 0) t[11:7]  = 5'd0;
        if ($urandom_range(0, 3) == 0) t[19:15] = 5'd0;
        return t;
    endfunction

    initial begin
        ena = 0; stall_IF = 0; exec_dup = 0; ifu_vld = 0; ifu_instruction = '0;
        reset_x = 1'b1;
        ref_reset();
        #1 reset_x = 1'b0;
        #1;
        chk_outputs("por");
        @(negedge clk);
        reset_x = 1'b1;

        // Pass-through of add x3,x1,x2
        step(1, 0, 0, 1, 32'h002081B3);
        chk("pass.inst", qed_instruction, 32'h002081B3);
        chk("pass.count", 32'(q_count), 32'd1);
        // Queue addi x5,x0,7 then replay both
        step(1, 0, 0, 1, 32'h00700293);
        step(1, 0, 1, 1, 32'hDEADBEEF);
        chk("replay0", qed_instruction, 32'h012889B3);
        step(1, 0, 0, 0, 32'h0);
        chk("replay1", qed_instruction, 32'h00700A93);
        chk("replay.done", 32'(dup_done), 32'd1);
        chk("replay.count", 32'(q_count), 32'd0);
        step(1, 0, 0, 0, 32'h0);
        chk("done.pulse", 32'(dup_done), 32'd0);

        // Empty replay request is ignored
        step(1, 0, 1, 0, 32'h0);
        chk("empty.rdy", 32'(ifu_rdy), 32'd1);
        chk("empty.done", 32'(dup_done), 32'd0);

        // Fill to DEPTH, then a ninth offer is refused
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 1, rand_inst());
        chk("full.count", 32'(q_count), 32'(DEPTH));
        step(1, 0, 0, 1, rand_inst());
        chk("full.vld", 32'(qed_vld_out), 32'd0);
        chk("full.rdy", 32'(ifu_rdy), 32'd0);

        // Replay with a three-cycle stall in the middle
        step(1, 0, 1, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, rand_inst());
        for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 0, 0, 32'h0);

        // Reset with three duplicates still pending
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, rand_inst());
        step(1, 0, 1, 0, 32'h0);
        do_reset();
        chk("post_rst.count", 32'(q_count), 32'd0);
        step(1, 0, 0, 0, 32'h0);
        chk("post_rst.rdy", 32'(ifu_rdy), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, rand_inst());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
